// File: rtl/lab4_sys_refill_arbiter.sv
// lab4_sys_refill_arbiter: 2:1 icache/dcache refill arbiter with in-order response routing.
// Define LAB4_SYS_REFILL_ARB_RR_EN for round-robin; otherwise dcache has fixed priority.
module lab4_sys_refill_arbiter #(
  parameter int p_num_outstanding = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [174:0] ireq_msg,
  input  logic         ireq_val,
  output logic         ireq_rdy,
  output logic [144:0] iresp_msg,
  output logic         iresp_val,
  input  logic         iresp_rdy,
  input  logic [174:0] dreq_msg,
  input  logic         dreq_val,
  output logic         dreq_rdy,
  output logic [144:0] dresp_msg,
  output logic         dresp_val,
  input  logic         dresp_rdy,
  output logic [174:0] mem_reqstream_msg,
  output logic         mem_reqstream_val,
  input  logic         mem_reqstream_rdy,
  input  logic [144:0] mem_respstream_msg,
  input  logic         mem_respstream_val,
  output logic         mem_respstream_rdy,
  output logic         arb_conflict
);
  localparam int aw = $clog2(p_num_outstanding);
  logic [aw:0]                  count;
  logic [aw-1:0]                wr_ptr, rd_ptr;
  logic [p_num_outstanding-1:0] owner;
  logic                         can_issue, has_out, grant, req_fire, resp_fire, head;
  assign can_issue = !reset && count < (aw+1)'(p_num_outstanding);
  assign has_out   = !reset && count != '0;
`ifdef LAB4_SYS_REFILL_ARB_RR_EN
  logic last_grant;
  assign grant = (ireq_val && dreq_val) ? !last_grant : dreq_val;
  always_ff @(posedge clk)
    if (reset) last_grant <= 1'b1;
    else if (req_fire) last_grant <= grant;
`else
  assign grant = dreq_val;
`endif
  assign mem_reqstream_msg  = grant ? dreq_msg : ireq_msg;
  assign mem_reqstream_val  = (grant ? dreq_val : ireq_val) && can_issue;
  assign ireq_rdy           = !grant && mem_reqstream_rdy && can_issue;
  assign dreq_rdy           = grant && mem_reqstream_rdy && can_issue;
  assign req_fire           = mem_reqstream_val && mem_reqstream_rdy;
  assign arb_conflict       = ireq_val && dreq_val && req_fire;
  // Owner of the oldest outstanding transaction steers the response.
  assign head               = owner[rd_ptr];
  assign iresp_msg          = mem_respstream_msg;
  assign dresp_msg          = mem_respstream_msg;
  assign iresp_val          = mem_respstream_val && has_out && !head;
  assign dresp_val          = mem_respstream_val && has_out && head;
  assign mem_respstream_rdy = (head ? dresp_rdy : iresp_rdy) && has_out;
  assign resp_fire          = mem_respstream_val && mem_respstream_rdy;
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (req_fire) begin
        owner[wr_ptr] <= grant;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (resp_fire) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (aw+1)'(req_fire) - (aw+1)'(resp_fire);
    end
  end
endmodule

// File: tb/tb_lab4_sys_refill_arbiter.sv
// tb_lab4_sys_refill_arbiter: scoreboard bench with requester sources and an in-order memory model.
module tb_lab4_sys_refill_arbiter;
  logic clk = 0, reset = 1;
  logic [174:0] ireq_msg = '0, dreq_msg = '0, mem_reqstream_msg;
  logic ireq_val = 0, dreq_val = 0, ireq_rdy, dreq_rdy;
  logic [144:0] iresp_msg, dresp_msg, mem_respstream_msg = '0;
  logic iresp_val, dresp_val, iresp_rdy = 1, dresp_rdy = 1;
  logic mem_reqstream_val, mem_reqstream_rdy = 1;
  logic mem_respstream_val = 0, mem_respstream_rdy, arb_conflict;
  lab4_sys_refill_arbiter #(.p_num_outstanding(4)) dut (
    .clk(clk), .reset(reset),
    .ireq_msg(ireq_msg), .ireq_val(ireq_val), .ireq_rdy(ireq_rdy),
    .iresp_msg(iresp_msg), .iresp_val(iresp_val), .iresp_rdy(iresp_rdy),
    .dreq_msg(dreq_msg), .dreq_val(dreq_val), .dreq_rdy(dreq_rdy),
    .dresp_msg(dresp_msg), .dresp_val(dresp_val), .dresp_rdy(dresp_rdy),
    .mem_reqstream_msg(mem_reqstream_msg), .mem_reqstream_val(mem_reqstream_val),
    .mem_reqstream_rdy(mem_reqstream_rdy),
    .mem_respstream_msg(mem_respstream_msg), .mem_respstream_val(mem_respstream_val),
    .mem_respstream_rdy(mem_respstream_rdy), .arb_conflict(arb_conflict));
  always #5 clk = ~clk;
  typedef struct {logic [144:0] msg; int rdy_at;} mresp_t;
  logic [174:0] i_q[$], d_q[$], exp_mem[$];
  logic [144:0] exp_i[$], exp_d[$];
  mresp_t mem_q[$];
  int cyc = 0, credits = -1, lat = 0;
  int errors = 0, checks = 0;
  int nreq = 0, ni = 0, nd = 0, nconf = 0, outst = 0;
  bit s_ifire, s_dfire, s_mreq, s_mresp, s_ir, s_dr;
  logic [174:0] s_mmsg;
  function automatic logic [174:0] req_of(logic [31:0] a);
    return {3'd0, a[7:0], a, 4'd0, {4{~a}}};
  endfunction
  function automatic logic [144:0] resp_of(logic [31:0] a);
    return {3'd0, a[7:0], 2'd0, 4'd0, {4{a ^ 32'h5a5a_5a5a}}};
  endfunction
  task automatic check(string n, logic [174:0] act, logic [174:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  // Monitor samples just before the rising edge; sources and memory update just after it.
  always begin
    @(negedge clk); #4;
    s_ifire = ireq_val && ireq_rdy;
    s_dfire = dreq_val && dreq_rdy;
    s_mreq  = mem_reqstream_val && mem_reqstream_rdy;
    s_mresp = mem_respstream_val && mem_respstream_rdy;
    s_ir    = iresp_val && iresp_rdy;
    s_dr    = dresp_val && dresp_rdy;
    s_mmsg  = mem_reqstream_msg;
    if (s_mreq) begin
      check("push_below_full", 175'(outst < 4), 175'(1));
      if (exp_mem.size() == 0) check("unexpected_mem_req", s_mmsg, '0);
      else check("mem_req_msg", s_mmsg, exp_mem.pop_front());
      nreq++; outst++;
    end
    if (s_ir) begin
      if (exp_i.size() == 0) check("unexpected_iresp", 175'(iresp_msg), '0);
      else check("iresp_msg", 175'(iresp_msg), 175'(exp_i.pop_front()));
      ni++;
    end
    if (s_dr) begin
      if (exp_d.size() == 0) check("unexpected_dresp", 175'(dresp_msg), '0);
      else check("dresp_msg", 175'(dresp_msg), 175'(exp_d.pop_front()));
      nd++;
    end
    if (s_mresp || s_ir || s_dr) begin
      check("resp_route_consistent", 175'({s_mresp, s_ir || s_dr}), 175'(2'b11));
      outst--;
    end
    if (arb_conflict) nconf++;
    @(posedge clk); #1;
    cyc++;
    if (s_ifire && i_q.size() > 0) void'(i_q.pop_front());
    if (s_dfire && d_q.size() > 0) void'(d_q.pop_front());
    if (s_mresp && mem_q.size() > 0) begin
      void'(mem_q.pop_front());
      if (credits > 0) credits--;
    end
    if (s_mreq) mem_q.push_back('{resp_of(s_mmsg[163:132]), cyc + lat});
    ireq_val = i_q.size() > 0;
    ireq_msg = ireq_val ? i_q[0] : '0;
    dreq_val = d_q.size() > 0;
    dreq_msg = dreq_val ? d_q[0] : '0;
    mem_respstream_val = mem_q.size() > 0 && mem_q[0].rdy_at <= cyc && credits != 0;
    mem_respstream_msg = mem_q.size() > 0 ? mem_q[0].msg : '0;
  end
  task automatic step(int n);
    repeat (n) @(negedge clk);
    #2;
  endtask
  task automatic issue(bit d, logic [31:0] a);
    if (d) begin d_q.push_back(req_of(a)); exp_d.push_back(resp_of(a)); end
    else begin i_q.push_back(req_of(a)); exp_i.push_back(resp_of(a)); end
  endtask
  task automatic do_reset();
    reset = 1;
    i_q.delete(); d_q.delete(); exp_mem.delete(); exp_i.delete(); exp_d.delete(); mem_q.delete();
    outst = 0; nreq = 0; ni = 0; nd = 0; nconf = 0;
  endtask
  task automatic wait_idle();
    bit done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      done = i_q.size() == 0 && d_q.size() == 0 && exp_mem.size() == 0 && exp_i.size() == 0 &&
             exp_d.size() == 0 && mem_q.size() == 0 && outst == 0;
      if (!done) step(1);
    end
    check("idle_within_budget", 175'(done), 175'(1));
  endtask
  task automatic wait_nreq(int target);
    for (int k = 0; k < 100 && nreq < target; k++) step(1);
    check("nreq_reached", 175'(nreq), 175'(target));
  endtask
  task automatic check_quiet(string tag);
    check({tag, "_ireq_rdy"}, 175'(ireq_rdy), 0);
    check({tag, "_dreq_rdy"}, 175'(dreq_rdy), 0);
    check({tag, "_mem_req_val"}, 175'(mem_reqstream_val), 0);
    check({tag, "_mem_resp_rdy"}, 175'(mem_respstream_rdy), 0);
    check({tag, "_iresp_val"}, 175'(iresp_val), 0);
    check({tag, "_dresp_val"}, 175'(dresp_val), 0);
    check({tag, "_conflict"}, 175'(arb_conflict), 0);
  endtask
  initial begin
    step(2);
    check_quiet("rst0");
    // single icache request, slow memory
    reset = 0; lat = 3;
    step(1);
    issue(0, 32'h1000); exp_mem.push_back(req_of(32'h1000));
    wait_idle();
    check("t1_nreq", 175'(nreq), 1);
    check("t1_ni", 175'(ni), 1);
    check("t1_nd", 175'(nd), 0);
    // both ports saturated
    do_reset(); lat = 0; step(2); reset = 0;
    for (int k = 0; k < 8; k++) begin
      issue(0, 32'h2000 + 32'(k * 16));
      issue(1, 32'h3000 + 32'(k * 16));
    end
`ifdef LAB4_SYS_REFILL_ARB_RR_EN
    for (int k = 0; k < 8; k++) begin
      exp_mem.push_back(req_of(32'h2000 + 32'(k * 16)));
      exp_mem.push_back(req_of(32'h3000 + 32'(k * 16)));
    end
`else
    for (int k = 0; k < 8; k++) exp_mem.push_back(req_of(32'h3000 + 32'(k * 16)));
    for (int k = 0; k < 8; k++) exp_mem.push_back(req_of(32'h2000 + 32'(k * 16)));
`endif
    wait_idle();
    check("t2_ni", 175'(ni), 8);
    check("t2_nd", 175'(nd), 8);
`ifdef LAB4_SYS_REFILL_ARB_RR_EN
    check("t2_conflicts", 175'(nconf), 15);
`else
    check("t2_conflicts", 175'(nconf), 8);
`endif
    // tracking FIFO fills, one release admits exactly one more
    do_reset(); step(2); reset = 0; credits = 0;
    for (int k = 0; k < 6; k++) begin
      issue(0, 32'h4000 + 32'(k * 16));
      exp_mem.push_back(req_of(32'h4000 + 32'(k * 16)));
    end
    step(12);
    check("t3_nreq_full", 175'(nreq), 4);
    check("t3_ireq_val", 175'(ireq_val), 1);
    check("t3_ireq_rdy_full", 175'(ireq_rdy), 0);
    check("t3_dreq_rdy_full", 175'(dreq_rdy), 0);
    credits = 1;
    step(4);
    check("t3_nreq_one_more", 175'(nreq), 5);
    check("t3_ni_one", 175'(ni), 1);
    check("t3_ireq_rdy_full2", 175'(ireq_rdy), 0);
    credits = -1;
    wait_idle();
    check("t3_nreq_all", 175'(nreq), 6);
    // dcache response stalled at head blocks a later icache response
    do_reset(); step(2); reset = 0; dresp_rdy = 0;
    issue(1, 32'h5000); exp_mem.push_back(req_of(32'h5000));
    wait_nreq(1);
    issue(0, 32'h6000); exp_mem.push_back(req_of(32'h6000));
    step(1);
    for (int k = 0; k < 5; k++) begin
      check("t4_mem_resp_rdy", 175'(mem_respstream_rdy), 0);
      check("t4_dresp_val", 175'(dresp_val), 1);
      check("t4_iresp_val", 175'(iresp_val), 0);
      step(1);
    end
    check("t4_nd_stalled", 175'(nd), 0);
    dresp_rdy = 1;
    wait_idle();
    check("t4_nd", 175'(nd), 1);
    check("t4_ni", 175'(ni), 1);
    // reset with three transactions outstanding
    do_reset(); step(2); reset = 0; credits = 0;
    for (int k = 0; k < 3; k++) begin
      issue(0, 32'h7000 + 32'(k * 16));
      exp_mem.push_back(req_of(32'h7000 + 32'(k * 16)));
    end
    wait_nreq(3);
    do_reset();
    issue(0, 32'h8000); issue(1, 32'h9000);
`ifdef LAB4_SYS_REFILL_ARB_RR_EN
    exp_mem.push_back(req_of(32'h8000)); exp_mem.push_back(req_of(32'h9000));
`else
    exp_mem.push_back(req_of(32'h9000)); exp_mem.push_back(req_of(32'h8000));
`endif
    credits = -1;
    step(1);
    check("t5_both_val_in_reset", 175'({ireq_val, dreq_val}), 175'(2'b11));
    check_quiet("rst_mid");
    reset = 0;
    wait_idle();
    check("t5_conflicts", 175'(nconf), 1);
    check("t5_ni", 175'(ni), 1);
    check("t5_nd", 175'(nd), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
